// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N-channel merge onto one memory port with in-order read-return routing.
// Optional ARB_LOCK_EN adds iLock/oLocked so one master can hold the port for atomic sequences.
module mem_port_arbiter #(
  parameter int NCH    = 2,
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [NCH-1:0]    iReq,
  input  logic [NCH-1:0]    iWe,
  input  logic [4*NCH-1:0]  iBE,
  input  logic [AW*NCH-1:0] iAddr,
  input  logic [32*NCH-1:0] iWData,
`ifdef ARB_LOCK_EN
  input  logic [NCH-1:0]    iLock,
  output logic              oLocked,
`endif
  output logic [NCH-1:0]    oGrant,
  output logic [NCH-1:0]    oRValid,
  output logic [31:0]       oRData,
  output logic              oMemRe,
  output logic              oMemWe,
  output logic [3:0]        oMemBE,
  output logic [AW-1:0]     oMemAddr,
  output logic [31:0]       oMemWData,
  input  logic [31:0]       iMemRData
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;

  logic [PW-1:0] ptr_q, ptr_d, sel, cand;
  logic hit;
  logic mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [NCH-1:0] rvalid_q, rvalid_d;
  logic [RD_LAT:0] rv_q, rv_d;
  logic [RD_LAT:0][PW-1:0] rid_q, rid_d;
`ifdef ARB_LOCK_EN
  logic lock_q, lock_d, release_c;
  logic [PW-1:0] owner_q, owner_d;
`endif

  always_comb begin
    hit = 1'b0;
    sel = '0;
    cand = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = PW'((int'(ptr_q) + i) % NCH);
      if (!hit && iReq[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
`ifdef ARB_LOCK_EN
    if (lock_q) begin
      hit = iReq[owner_q];
      sel = owner_q;
    end
`endif
    if (iRST) hit = 1'b0;
  end

  assign oGrant = hit ? NCH'(1) << sel : '0;

  always_comb begin
    ptr_d = hit ? (sel == PW'(NCH - 1) ? '0 : sel + 1'b1) : ptr_q;
`ifdef ARB_LOCK_EN
    release_c = lock_q && !(iReq[owner_q] && iLock[owner_q]);
    ptr_d = lock_q ? (release_c ? (owner_q == PW'(NCH - 1) ? '0 : owner_q + 1'b1) : ptr_q) : ptr_d;
    lock_d = lock_q ? !release_c : (hit && iLock[sel]);
    owner_d = (!lock_q && hit) ? sel : owner_q;
`endif
    mem_re_d = hit & ~iWe[sel];
    mem_we_d = hit & iWe[sel];
    mem_be_d = hit ? iBE[4*sel +: 4] : mem_be_q;
    mem_addr_d = hit ? iAddr[AW*sel +: AW] : mem_addr_q;
    mem_wdata_d = hit ? iWData[32*sel +: 32] : mem_wdata_q;
    // stage 0 aligns with oMemRe; stage RD_LAT aligns with valid iMemRData
    rv_d = {rv_q[RD_LAT-1:0], mem_re_d};
    rid_d = {rid_q[RD_LAT-1:0], sel};
    rvalid_d = rv_q[RD_LAT] ? NCH'(1) << rid_q[RD_LAT] : '0;
    rdata_d = rv_q[RD_LAT] ? iMemRData : rdata_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ptr_q <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_be_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rdata_q <= '0;
      rvalid_q <= '0;
      rv_q <= '0;
      rid_q <= '0;
`ifdef ARB_LOCK_EN
      lock_q <= 1'b0;
      owner_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      mem_be_q <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      rv_q <= rv_d;
      rid_q <= rid_d;
`ifdef ARB_LOCK_EN
      lock_q <= lock_d;
      owner_q <= owner_d;
`endif
    end
  end

  assign oMemRe = mem_re_q;
  assign oMemWe = mem_we_q;
  assign oMemBE = mem_be_q;
  assign oMemAddr = mem_addr_q;
  assign oMemWData = mem_wdata_q;
  assign oRData = rdata_q;
  assign oRValid = rvalid_q;
`ifdef ARB_LOCK_EN
  assign oLocked = lock_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of a 2ch/lat1 and a 4ch/lat3 arbiter against hand-computed values.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] req2 = '0, we2 = '0, gnt2, rv2;
  logic [7:0] be2 = '0;
  logic [63:0] ad2 = '0, wd2 = '0;
  logic [31:0] rd2, mwd2, mrd2, mad2, a2;
  logic re2o, we2o;
  logic [3:0] be2o;

  logic [3:0] req4 = '0, we4 = '0, gnt4, rv4, be4o;
  logic [15:0] be4 = '0;
  logic [127:0] ad4 = '0, wd4 = '0;
  logic [31:0] rd4, mwd4, mrd4, mad4;
  logic [31:0] a4 [0:2];
  logic re4o, we4o;
`ifdef ARB_LOCK_EN
  logic [1:0] lk2 = '0;
  logic [3:0] lk4 = '0;
  logic lkd2, lkd4;
`endif

  mem_port_arbiter #(.NCH(2), .RD_LAT(1), .AW(32)) u2 (
    .iCLK(clk), .iRST(rst), .iReq(req2), .iWe(we2), .iBE(be2), .iAddr(ad2), .iWData(wd2),
`ifdef ARB_LOCK_EN
    .iLock(lk2), .oLocked(lkd2),
`endif
    .oGrant(gnt2), .oRValid(rv2), .oRData(rd2), .oMemRe(re2o), .oMemWe(we2o), .oMemBE(be2o),
    .oMemAddr(mad2), .oMemWData(mwd2), .iMemRData(mrd2));

  mem_port_arbiter #(.NCH(4), .RD_LAT(3), .AW(32)) u4 (
    .iCLK(clk), .iRST(rst), .iReq(req4), .iWe(we4), .iBE(be4), .iAddr(ad4), .iWData(wd4),
`ifdef ARB_LOCK_EN
    .iLock(lk4), .oLocked(lkd4),
`endif
    .oGrant(gnt4), .oRValid(rv4), .oRData(rd4), .oMemRe(re4o), .oMemWe(we4o), .oMemBE(be4o),
    .oMemAddr(mad4), .oMemWData(mwd4), .iMemRData(mrd4));

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : a ^ 32'hA5A50000;
  endfunction

  always @(posedge clk) begin
    a2 <= mad2;
    a4[0] <= mad4;
    a4[1] <= a4[0];
    a4[2] <= a4[1];
  end
  assign mrd2 = mem_f(a2);
  assign mrd4 = mem_f(a4[2]);

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    req2 = 2'b11;
    req4 = 4'b1111;
    step();
    step();
    #1;
    chk("rst_gnt2", gnt2, 2'b00);
    chk("rst_gnt4", gnt4, 4'b0000);
    chk("rst_re", re2o, 1'b0);
    chk("rst_we", we2o, 1'b0);
    chk("rst_rv", rv2, 2'b00);
    chk("rst_addr", mad2, 32'h0);
    chk("rst_rdata", rd2, 32'h0);
    req2 = '0;
    req4 = '0;
    rst = 1'b0;

    ad2 = {32'h0, 32'h100};
    req2 = 2'b01;
    #1 chk("t1_gnt", gnt2, 2'b01);
    step();
    req2 = '0;
    chk("t1_re", re2o, 1'b1);
    chk("t1_addr", mad2, 32'h100);
    chk("t1_rv_e0", rv2, 2'b00);
    step();
    chk("t1_rv_e1", rv2, 2'b00);
    step();
    chk("t1_rv", rv2, 2'b01);
    chk("t1_rdata", rd2, 32'hDEADBEEF);
    step();
    chk("t1_rv_end", rv2, 2'b00);

    do_reset();
    ad2 = {32'h20, 32'h10};
    for (int t = 0; t < 8; t++) begin
      req2 = t < 6 ? 2'b11 : 2'b00;
      #1;
      if (t < 6) chk($sformatf("t2_gnt%0d", t), gnt2, (t % 2) ? 2'b10 : 2'b01);
      step();
      if (t == 1) chk("t2_rv_e1", rv2, 2'b00);
      if (t >= 2) begin
        chk($sformatf("t2_rv%0d", t), rv2, ((t - 2) % 2) ? 2'b10 : 2'b01);
        chk($sformatf("t2_rd%0d", t), rd2, ((t - 2) % 2) ? 32'hA5A50020 : 32'hA5A50010);
      end
    end
    req2 = '0;

    ad2 = {32'h40, 32'h0};
    wd2 = {32'h1234, 32'h0};
    be2 = 8'b0011_0000;
    we2 = 2'b10;
    req2 = 2'b10;
    #1 chk("t3_gnt", gnt2, 2'b10);
    step();
    req2 = '0;
    we2 = '0;
    chk("t3_we", we2o, 1'b1);
    chk("t3_re", re2o, 1'b0);
    chk("t3_be", be2o, 4'b0011);
    chk("t3_wd", mwd2, 32'h1234);
    chk("t3_addr", mad2, 32'h40);
    for (int t = 0; t < 3; t++) begin
      step();
      chk($sformatf("t3_norv%0d", t), rv2, 2'b00);
    end

    ad4 = {32'h300, 32'h0, 32'h310, 32'h0};
    req4 = 4'b1000;
    #1 chk("t4_gnt3", gnt4, 4'b1000);
    step();
    req4 = 4'b0010;
    #1 chk("t4_gnt1", gnt4, 4'b0010);
    step();
    req4 = '0;
    for (int t = 2; t <= 6; t++) begin
      step();
      chk($sformatf("t4_rv_e%0d", t), rv4, t == 4 ? 4'b1000 : t == 5 ? 4'b0010 : 4'b0000);
      if (t == 4) chk("t4_rd3", rd4, 32'hA5A50300);
      if (t == 5) chk("t4_rd1", rd4, 32'hA5A50310);
    end

    ad2 = {32'h20, 32'h100};
    req2 = 2'b01;
    #1 chk("t5_gnt", gnt2, 2'b01);
    step();
    req2 = 2'b11;
    rst = 1'b1;
    #1 chk("t5_gnt_in_rst", gnt2, 2'b00);
    step();
    rst = 1'b0;
    req2 = '0;
    chk("t5_rv_e1", rv2, 2'b00);
    for (int t = 2; t < 4; t++) begin
      step();
      chk($sformatf("t5_rv_e%0d", t), rv2, 2'b00);
    end
    req2 = 2'b11;
    #1 chk("t5_ptr0", gnt2, 2'b01);
    req2 = 2'b10;
    #1 chk("t5_ch1", gnt2, 2'b10);
    step();
    req2 = '0;

`ifdef ARB_LOCK_EN
    do_reset();
    chk("lk_rst", lkd2, 1'b0);
    req2 = 2'b11;
    lk2 = 2'b01;
    for (int t = 0; t < 3; t++) begin
      #1 chk($sformatf("lk_gnt%0d", t), gnt2, 2'b01);
      step();
      chk($sformatf("lk_on%0d", t), lkd2, 1'b1);
    end
    req2 = 2'b10;
    lk2 = 2'b00;
    #1 chk("lk_hold", gnt2, 2'b00);
    step();
    chk("lk_off", lkd2, 1'b0);
    #1 chk("lk_ch1", gnt2, 2'b10);
    step();
    req2 = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
